// File: rtl/mu0_mem_io.sv
// MU0 memory and memory-mapped I/O: 4K-word RAM plus OUT/IN/TXD/STATUS/CYCLE page.
// Define MU0_MEM_IO_CYCLE_EN to include the free-running CYCLE counter.
module mu0_mem_io #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] IO_BASE    = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] address,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic [15:0] out_port,
    input  logic [15:0] in_port,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [11:0] io_off;
    logic        is_io;
    logic        io_hit;
    logic [3:0]  io_sel;

    assign io_off = address - IO_BASE;
    assign is_io  = (address >= IO_BASE);
    // Addresses past the 16-word page still never reach RAM; they read 0.
    assign io_hit = is_io && (io_off[11:4] == 8'h00);
    assign io_sel = io_off[3:0];

    logic wr_out, wr_txd, wr_stat;
    assign wr_out  = memory_write && io_hit && (io_sel == 4'd0);
    assign wr_txd  = memory_write && io_hit && (io_sel == 4'd2);
    assign wr_stat = memory_write && io_hit && (io_sel == 4'd3);

    logic [15:0] ram_q [0:4095];

    always_ff @(posedge clk) begin
        if (memory_write && !is_io) begin
            ram_q[address] <= cpu_wdata;
        end
    end

    logic [15:0] out_q, out_d;
    logic [15:0] sync1_q, sync2_q;

    assign out_d    = wr_out ? cpu_wdata : out_q;
    assign out_port = out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            out_q   <= out_d;
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 16'h0000 : fifo_q[rd_ptr_q];
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push     = wr_txd && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (wr_txd && !push) begin
            ovf_d = 1'b1;
        end else if (wr_stat) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    logic [15:0] status;

    always_comb begin
        status         = '0;
        status[0]      = empty;
        status[1]      = full;
        status[2]      = ovf_q;
        status[4 +: CW] = cnt_q;
    end

    logic [15:0] cyc_val;

`ifdef MU0_MEM_IO_CYCLE_EN
    logic        wr_cyc;
    logic [15:0] cyc_q, cyc_d;

    assign wr_cyc = memory_write && io_hit && (io_sel == 4'd4);
    // The write cycle itself counts as zero, so the next read sees 1.
    assign cyc_d   = wr_cyc ? 16'd1 : cyc_q + 16'd1;
    assign cyc_val = cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    assign cyc_val = 16'h0000;
`endif

    always_comb begin
        cpu_rdata = 16'h0000;
        if (memory_read) begin
            if (!is_io) begin
                cpu_rdata = ram_q[address];
            end else if (io_hit) begin
                unique case (io_sel)
                    4'd0:    cpu_rdata = out_q;
                    4'd1:    cpu_rdata = sync2_q;
                    4'd3:    cpu_rdata = status;
                    4'd4:    cpu_rdata = cyc_val;
                    default: cpu_rdata = 16'h0000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mu0_mem_io.sv
// Self-checking bench for mu0_mem_io with a TX stream scoreboard.
module tb_mu0_mem_io;

    localparam int FD = 4;

    logic        clk;
    logic        rst;
    logic [11:0] address;
    logic        memory_read;
    logic        memory_write;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic [15:0] out_port;
    logic [15:0] in_port;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_cmp;
    int n_mis;
    logic [15:0] exp_q[$];

    mu0_mem_io #(.FIFO_DEPTH(FD), .IO_BASE(12'hFF0)) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .memory_read(memory_read),
        .memory_write(memory_write),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .out_port(out_port),
        .in_port(in_port),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic rd(input logic [11:0] a, output logic [15:0] d);
        address = a;
        memory_read = 1'b1;
        memory_write = 1'b0;
        #1;
        d = cpu_rdata;
        memory_read = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        address = a;
        cpu_wdata = d;
        memory_write = 1'b1;
        memory_read = 1'b0;
        @(negedge clk);
        memory_write = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input bit accepted);
        if (accepted) exp_q.push_back(d);
        wr(12'hFF2, d);
    endtask

    task automatic drain(input string nm);
        logic [15:0] e;
        tx_ready = 1'b1;
        for (int i = 0; i < 3 * FD && exp_q.size() > 0; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1) begin
                n_mis++;
                $display("FAIL %s_valid: got %b want 1", nm, tx_valid);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (tx_data !== e) begin
                    n_mis++;
                    $display("FAIL %s_data: got %h want %h", nm, tx_data, e);
                end
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL %s_timeout: %0d words left, want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0 || out_port !== 16'h0 || tx_data !== 16'h0) begin
            n_mis++;
            $display("FAIL reset_outs: valid=%b out=%h data=%h want 0/0/0",
                     tx_valid, out_port, tx_data);
        end
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0001) begin
            n_mis++;
            $display("FAIL reset_status: got %h want 0001", d);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cpu_rdata !== 16'h0000) begin
            n_mis++;
            $display("FAIL reset_rdata_idle: got %h want 0000", cpu_rdata);
        end
    endtask

    task automatic test_ram();
        logic [15:0] d;
        wr(12'h010, 16'h1234);
        rd(12'h010, d);
        n_cmp++;
        if (d !== 16'h1234) begin
            n_mis++;
            $display("FAIL ram_read: got %h want 1234", d);
        end
        address = 12'h010;
        #1;
        n_cmp++;
        if (cpu_rdata !== 16'h0000) begin
            n_mis++;
            $display("FAIL ram_noread: got %h want 0000", cpu_rdata);
        end
        wr(12'hFEF, 16'hBEEF);
        rd(12'hFEF, d);
        n_cmp++;
        if (d !== 16'hBEEF) begin
            n_mis++;
            $display("FAIL ram_top: got %h want beef", d);
        end
        // read and write in the same cycle return the old word
        address = 12'h010;
        cpu_wdata = 16'h5555;
        memory_read = 1'b1;
        memory_write = 1'b1;
        #1;
        n_cmp++;
        if (cpu_rdata !== 16'h1234) begin
            n_mis++;
            $display("FAIL ram_rw_same: got %h want 1234", cpu_rdata);
        end
        @(negedge clk);
        memory_write = 1'b0;
        memory_read = 1'b0;
        rd(12'h010, d);
        n_cmp++;
        if (d !== 16'h5555) begin
            n_mis++;
            $display("FAIL ram_rw_after: got %h want 5555", d);
        end
        wr(12'h010, 16'h1234);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(12'h010, d);
        n_cmp++;
        if (d !== 16'h1234) begin
            n_mis++;
            $display("FAIL ram_keep_reset: got %h want 1234", d);
        end
        @(negedge clk);
    endtask

    task automatic test_out_in();
        logic [15:0] d;
        wr(12'hFF0, 16'hA5A5);
        n_cmp++;
        if (out_port !== 16'hA5A5) begin
            n_mis++;
            $display("FAIL out_port: got %h want a5a5", out_port);
        end
        rd(12'hFF0, d);
        n_cmp++;
        if (d !== 16'hA5A5) begin
            n_mis++;
            $display("FAIL out_read: got %h want a5a5", d);
        end
        in_port = 16'h00C3;
        rd(12'hFF1, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_mis++;
            $display("FAIL in_edge0: got %h want 0000", d);
        end
        @(negedge clk);
        rd(12'hFF1, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_mis++;
            $display("FAIL in_edge1: got %h want 0000", d);
        end
        @(negedge clk);
        rd(12'hFF1, d);
        n_cmp++;
        if (d !== 16'h00C3) begin
            n_mis++;
            $display("FAIL in_edge2: got %h want 00c3", d);
        end
        @(negedge clk);
    endtask

    task automatic test_fifo_overflow();
        logic [15:0] d;
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'(i), 1'b1);
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0042) begin
            n_mis++;
            $display("FAIL fifo_full_status: got %h want 0042", d);
        end
        push(16'd5, 1'b0);
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0046) begin
            n_mis++;
            $display("FAIL fifo_ovf_status: got %h want 0046", d);
        end
        n_cmp++;
        if (tx_data !== exp_q[0]) begin
            n_mis++;
            $display("FAIL fifo_head_stable: got %h want %h", tx_data, exp_q[0]);
        end
        wr(12'hFF3, 16'hFFFF);
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0042) begin
            n_mis++;
            $display("FAIL fifo_ovf_clear: got %h want 0042", d);
        end
    endtask

    task automatic test_drain();
        logic [15:0] d;
        logic [15:0] e;
        drain("drain1");
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0001 || tx_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL drain_empty: status=%h valid=%b want 0001/0", d, tx_valid);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0001) begin
            n_mis++;
            $display("FAIL ready_when_empty: got %h want 0001", d);
        end
        for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i), 1'b1);
        // full, pop and push in the same cycle
        tx_ready = 1'b1;
        address = 12'hFF2;
        cpu_wdata = 16'h0014;
        memory_write = 1'b1;
        #1;
        e = exp_q.pop_front();
        exp_q.push_back(16'h0014);
        n_cmp++;
        if (tx_data !== e) begin
            n_mis++;
            $display("FAIL pushpop_head: got %h want %h", tx_data, e);
        end
        @(negedge clk);
        memory_write = 1'b0;
        tx_ready = 1'b0;
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0042) begin
            n_mis++;
            $display("FAIL pushpop_status: got %h want 0042", d);
        end
        drain("drain2");
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        push(16'h00AA, 1'b1);
        push(16'h00BB, 1'b1);
        wr(12'hFF0, 16'hFFFF);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_cmp++;
        if (tx_valid !== 1'b0 || out_port !== 16'h0000) begin
            n_mis++;
            $display("FAIL midreset_async: valid=%b out=%h want 0/0000",
                     tx_valid, out_port);
        end
        rd(12'hFF3, d);
        n_cmp++;
        if (d !== 16'h0001) begin
            n_mis++;
            $display("FAIL midreset_status: got %h want 0001", d);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cycle();
        logic [15:0] d;
        wr(12'hFF4, 16'h7777);
`ifdef MU0_MEM_IO_CYCLE_EN
        for (int i = 1; i <= 3; i++) begin
            rd(12'hFF4, d);
            n_cmp++;
            if (d !== 16'(i)) begin
                n_mis++;
                $display("FAIL cycle_count%0d: got %h want %h", i, d, 16'(i));
            end
            if (i < 3) @(negedge clk);
        end
        repeat (65532) @(negedge clk);
        rd(12'hFF4, d);
        n_cmp++;
        if (d !== 16'hFFFF) begin
            n_mis++;
            $display("FAIL cycle_max: got %h want ffff", d);
        end
        @(negedge clk);
        rd(12'hFF4, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_mis++;
            $display("FAIL cycle_wrap: got %h want 0000", d);
        end
`else
        rd(12'hFF4, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_mis++;
            $display("FAIL cycle_absent: got %h want 0000", d);
        end
`endif
        wr(12'hFF7, 16'h1111);
        rd(12'hFF7, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_mis++;
            $display("FAIL unmapped: got %h want 0000", d);
        end
        rd(12'hFF2, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_mis++;
            $display("FAIL txd_read: got %h want 0000", d);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        address = '0;
        memory_read = 1'b0;
        memory_write = 1'b0;
        cpu_wdata = '0;
        in_port = '0;
        tx_ready = 1'b0;
        test_reset();
        test_ram();
        test_out_in();
        test_fifo_overflow();
        test_drain();
        test_reset_mid();
        test_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mu0_mem_io.md
Name: mu0_mem_io

Overview:
Memory and memory-mapped I/O stage directly downstream of the MU0 core. It serves the core's single-cycle bus: address, read enable, write enable, write data in, read data out. It contains a 4K-word program/data RAM and a small I/O page: output port, synchronised input port, transmit FIFO with valid/ready stream, and cycle counter. The core samples read data at the clock edge that ends the access cycle, so reads are combinational and writes are synchronous.

Parameters:
FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16
IO_BASE, 12'hFF0, base of the 16-word I/O page; addresses >= IO_BASE never reach RAM

Ports:
clk  input  1  system clock
rst  input  1  master reset, asynchronous, active-high
address  input  12  word address from core
memory_read  input  1  read enable from core
memory_write  input  1  write enable from core
cpu_wdata  input  16  write data (core accumulator)
cpu_rdata  output  16  read data to core
out_port  output  16  output port register
in_port  input  16  asynchronous external input
tx_data  output  16  FIFO head word
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head this cycle

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Address map:
  - address < IO_BASE: RAM
  - IO_BASE+0: OUT (R/W)
  - +1: IN (R)
  - +2: TXD (W push; reads 0)
  - +3: STATUS (R; write clears sticky)
  - +4: CYCLE (R; write clears)
  - +5..+15: read 0, writes ignored
- Reads: cpu_rdata is combinational from address while memory_read=1; 16'h0000 when memory_read=0. Zero-latency; no wait states.
- Writes: take effect at the rising clk edge with memory_write=1. If memory_read and memory_write are both 1, the read returns the pre-write value.
- RAM: 4096x16, not cleared by reset; contents hold across reset.
- OUT:
  - Reset 16'h0000.
  - Write updates out_port on the next edge.
  - Reading OUT returns the current register value.
- IN: in_port passes through a two-flop synchroniser (reset 0). A change on in_port is readable two edges later.
- TX FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_valid = (count != 0). tx_data = head entry; 0 when empty.
  - Pop occurs when tx_valid && tx_ready.
  - Push (write to TXD) is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leave count unchanged.
  - A push while full with no pop is dropped and sets overflow.
  - tx_ready while empty has no effect.
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
- STATUS read:
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow (sticky)
  - bits[8:4] = count
  - other bits 0
  - Write (any data) clears overflow. If an overflowing push occurs in the same cycle, overflow remains set.
- CYCLE: 16-bit free-running counter, +1 every clk, wraps FFFF->0000. A write loads 0, so the next cycle reads 1.
- Reset (any time, including mid-transfer):
  - FIFO emptied: count 0, tx_valid 0 immediately (asynchronous).
  - OUT, synchroniser, CYCLE and overflow all 0.
  - cpu_rdata follows the combinational read rule.

Optional Feature:
MU0_MEM_IO_CYCLE_EN
- Defined: CYCLE counter present as above.
- Undefined: no counter flops. IO_BASE+4 reads 16'h0000 and writes are ignored (behaves as an unmapped address).

Test Plan:
1. RAM: write 16'h1234 to 12'h010, then read 12'h010 -> cpu_rdata=16'h1234. Read with memory_read=0 -> 16'h0000. Assert rst, then re-read -> 16'h1234 (RAM not reset).
2. OUT/IN: write 16'hA5A5 to FF0 -> out_port=A5A5 after the edge, reading FF0 returns A5A5. Drive in_port=16'h00C3 -> read FF1 returns old value for 2 edges, then 00C3.
3. FIFO fill/overflow, tx_ready=0: push 1,2,3,4 -> STATUS=16'h0042 (count 4, full). Push 5 -> dropped, STATUS=16'h0046. Write FF3 -> STATUS=16'h0042.
4. Drain with tx_ready=1 -> tx_data sequence 1,2,3,4 on consecutive cycles, then tx_valid=0 and STATUS=16'h0001. Push while full with simultaneous pop -> accepted, count stays 4, no overflow.
5. Reset mid-operation: 2 entries queued, OUT=FFFF, rst pulsed between edges -> tx_valid=0, out_port=0, STATUS=16'h0001 immediately.
6. CYCLE (macro defined): write FF4, read on following cycles -> 1,2,3. Counter wraps FFFF->0000. With macro undefined -> FF4 reads 0.
